// File: rtl/unidade_divisao_sequencial.sv
`default_nettype none
// ============================================================================
// Module   : unidade_divisao_sequencial
// Purpose  : Multi-cycle unsigned divide/modulo unit. Restoring division,
//            one quotient bit per clock. This unit performs the DIV and MOD
//            ALU operations so they do not sit on the combinational ALU path.
// Ports    : clock      - system clock, rising-edge active
//            reset      - synchronous, active-high reset
//            start      - request strobe, honoured only while idle
//            aluOp      - operation select (OP_DIV / OP_MOD), sampled with start
//            A, B       - dividend / divisor, sampled with start
//            resultado  - quotient or remainder, held until the next completion
//            busy       - operation in progress
//            done       - one-cycle completion pulse
//            divByZero  - completed operation had B == 0
// Revision : 1.0 - initial release
// ============================================================================
module unidade_divisao_sequencial #(
    parameter int         WIDTH  = 32,
    parameter logic [4:0] OP_DIV = 5'b00011,
    parameter logic [4:0] OP_MOD = 5'b00100
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       aluOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] resultado,
    output logic             busy,
    output logic             done,
    output logic             divByZero
);

    localparam int         c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CALC  = 2'd1;
    localparam logic [1:0] c_FIM   = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_nextState;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [c_CNT_W-1:0] r_count;
    logic             r_isMod;
    logic             r_divZero;
    logic [WIDTH-1:0] r_resultado;
    logic             r_divByZero;

    logic             w_opValid;
    logic             w_accept;
    logic             w_lastStep;
    logic [WIDTH:0]   w_remShift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_remStep;
    logic [WIDTH-1:0] w_quoStep;

    assign w_opValid  = (aluOp == OP_DIV) || (aluOp == OP_MOD);
    assign w_accept   = (r_state == c_IDLE) && start && w_opValid;
    assign w_lastStep = (r_state == c_CALC) && (r_count == c_CNT_W'(1));

    // One restoring step. The shifted remainder is below 2*B, so the
    // WIDTH+1-bit trial difference is negative exactly when its MSB is set.
    assign w_remShift = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_remShift - {1'b0, r_divisor};

    // A divide-by-zero request was preloaded with its final values, so the
    // single pass through CALC only serves as the one-cycle busy slot.
    always_comb begin
        w_remStep = r_rem;
        w_quoStep = r_quo;
        if (!r_divZero) begin
            if (!w_trial[WIDTH]) begin
                w_remStep = w_trial[WIDTH-1:0];
            end else begin
                w_remStep = w_remShift[WIDTH-1:0];
            end
            w_quoStep = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE:  if (w_accept)   w_nextState = c_CALC;
            c_CALC:  if (w_lastStep) w_nextState = c_FIM;
            c_FIM:   w_nextState = c_IDLE;
            default: w_nextState = c_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            r_divisor   <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_count     <= '0;
            r_isMod     <= 1'b0;
            r_divZero   <= 1'b0;
            r_resultado <= '0;
            r_divByZero <= 1'b0;
        end else begin
            if (w_accept) begin
                r_divisor <= B;
                r_isMod   <= (aluOp == OP_MOD);
                if (B == '0) begin
                    r_divZero <= 1'b1;
                    r_rem     <= A;
                    r_quo     <= '1;
                    r_count   <= c_CNT_W'(1);
                end else begin
                    r_divZero <= 1'b0;
                    r_rem     <= '0;
                    r_quo     <= A;
                    r_count   <= c_CNT_W'(WIDTH);
                end
            end else if (r_state == c_CALC) begin
                r_rem   <= w_remStep;
                r_quo   <= w_quoStep;
                r_count <= r_count - c_CNT_W'(1);
                if (w_lastStep) begin
                    r_resultado <= r_isMod ? w_remStep : w_quoStep;
                    r_divByZero <= r_divZero;
                end
            end
        end
    end

    assign resultado = r_resultado;
    assign divByZero = r_divByZero;
    assign busy      = (r_state == c_CALC);
    assign done      = (r_state == c_FIM);

endmodule
`default_nettype wire

// File: tb/tb_unidade_divisao_sequencial.sv
`default_nettype none
// ============================================================================
// Module   : tb_unidade_divisao_sequencial
// Purpose  : Self-checking bench for unidade_divisao_sequencial. Directed
//            scenarios plus a randomized comparison against / and %.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unidade_divisao_sequencial;

    localparam int         WIDTH  = 32;
    localparam logic [4:0] OP_DIV = 5'b00011;
    localparam logic [4:0] OP_MOD = 5'b00100;

    logic             clock;
    logic             reset;
    logic             start;
    logic [4:0]       aluOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] resultado;
    logic             busy;
    logic             done;
    logic             divByZero;

    int total;
    int bad;

    unidade_divisao_sequencial #(
        .WIDTH (WIDTH),
        .OP_DIV(OP_DIV),
        .OP_MOD(OP_MOD)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .aluOp    (aluOp),
        .A        (A),
        .B        (B),
        .resultado(resultado),
        .busy     (busy),
        .done     (done),
        .divByZero(divByZero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // Issue one request and follow it to completion. lat counts sampled
    // cycles from the accept edge to the cycle where done is seen; -1 on timeout.
    task automatic run_op(input logic [4:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b,
                          output logic [WIDTH-1:0] res, output logic dz,
                          output int lat, output int busyCnt, output logic doneAfter);
        @(negedge clock);
        start = 1'b1; aluOp = op; A = a; B = b;
        @(posedge clock);
        #1;
        start = 1'b0; A = ~a; B = ~b;
        lat = -1; busyCnt = 0; res = '0; dz = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            if (busy) busyCnt++;
            if (done) begin
                lat = i; res = resultado; dz = divByZero;
                break;
            end
        end
        @(negedge clock);
        doneAfter = done | busy;
    endtask

    task automatic check_op(input string name, input logic [4:0] op,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] expRes, input logic expDz,
                            input int expLat, input int expBusy);
        logic [WIDTH-1:0] res;
        logic dz, after;
        int lat, bc;
        run_op(op, a, b, res, dz, lat, bc, after);
        total++;
        if (res !== expRes || dz !== expDz) begin
            bad++;
            $display("FAIL %s result: got %h dz=%b, required %h dz=%b", name, res, dz, expRes, expDz);
        end
        total++;
        if (lat !== expLat || bc !== expBusy) begin
            bad++;
            $display("FAIL %s timing: got lat=%0d busy=%0d, required lat=%0d busy=%0d",
                     name, lat, bc, expLat, expBusy);
        end
        total++;
        if (after !== 1'b0) begin
            bad++;
            $display("FAIL %s pulse: got done|busy=%b after completion, required 0", name, after);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; aluOp = '0; A = '0; B = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++;
        if (resultado !== '0 || busy !== 1'b0 || done !== 1'b0 || divByZero !== 1'b0) begin
            bad++;
            $display("FAIL reset: got res=%h busy=%b done=%b dz=%b, required all 0",
                     resultado, busy, done, divByZero);
        end
        reset = 1'b0;
    endtask

    task automatic test_div_mod();
        check_op("div100_7", OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 33, 32);
        check_op("mod100_7", OP_MOD, 32'd100, 32'd7, 32'd2, 1'b0, 33, 32);
        check_op("div5_9",   OP_DIV, 32'd5, 32'd9, 32'd0, 1'b0, 33, 32);
        check_op("mod5_9",   OP_MOD, 32'd5, 32'd9, 32'd5, 1'b0, 33, 32);
    endtask

    task automatic test_extremes();
        check_op("divmax_1",   OP_DIV, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1'b0, 33, 32);
        check_op("divmax_max", OP_DIV, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0, 33, 32);
        check_op("modmax_max", OP_MOD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 33, 32);
        check_op("div0_3",     OP_DIV, 32'd0, 32'd3, 32'd0, 1'b0, 33, 32);
        check_op("mod0_3",     OP_MOD, 32'd0, 32'd3, 32'd0, 1'b0, 33, 32);
    endtask

    task automatic test_div_by_zero();
        check_op("div42_0", OP_DIV, 32'd42, 32'd0, 32'hFFFFFFFF, 1'b1, 2, 1);
        check_op("mod42_0", OP_MOD, 32'd42, 32'd0, 32'd42, 1'b1, 2, 1);
        // Flag must clear on the next normal completion.
        check_op("div9_3",  OP_DIV, 32'd9, 32'd3, 32'd3, 1'b0, 33, 32);
    endtask

    task automatic test_invalid_op();
        int seen;
        logic [WIDTH-1:0] held;
        held = resultado;
        seen = 0;
        @(negedge clock);
        start = 1'b1; aluOp = 5'b00000; A = 32'd77; B = 32'd5;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (busy || done) seen++;
            @(negedge clock);
        end
        total++;
        if (seen !== 0 || resultado !== held) begin
            bad++;
            $display("FAIL invalid_op: got %0d busy/done cycles res=%h, required 0 and %h",
                     seen, resultado, held);
        end
    endtask

    task automatic test_back_to_back();
        int dones, firstLat, heldBad;
        logic [WIDTH-1:0] res;
        dones = 0; firstLat = -1; heldBad = 0; res = '0;
        @(negedge clock);
        start = 1'b1; aluOp = OP_DIV; A = 32'd100; B = 32'd7;
        @(posedge clock);
        #1 start = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clock);
            if (i == 5) begin
                start = 1'b1; A = 32'd9; B = 32'd3; aluOp = OP_DIV;
            end else if (i == 33) begin
                // start landing on the FIM cycle must also be dropped
                start = 1'b1; A = 32'd8; B = 32'd2; aluOp = OP_MOD;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                dones++;
                if (firstLat < 0) begin
                    firstLat = i; res = resultado;
                end
            end
        end
        start = 1'b0;
        total++;
        if (dones !== 1 || firstLat !== 33 || res !== 32'd14) begin
            bad++;
            $display("FAIL start_while_busy: got dones=%0d lat=%0d res=%0d, required 1 33 14",
                     dones, firstLat, res);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (resultado !== 32'd14 || busy || done) heldBad++;
        end
        total++;
        if (heldBad !== 0) begin
            bad++;
            $display("FAIL hold_result: got %0d bad idle cycles res=%0d, required 0 and 14",
                     heldBad, resultado);
        end
    endtask

    task automatic test_reset_mid_op();
        int dones;
        dones = 0;
        @(negedge clock);
        start = 1'b1; aluOp = OP_DIV; A = 32'd100; B = 32'd7;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (resultado !== '0 || busy !== 1'b0 || done !== 1'b0 || divByZero !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_op: got res=%h busy=%b done=%b dz=%b, required all 0",
                     resultado, busy, done, divByZero);
        end
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (done || busy) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL reset_discard: got %0d busy/done cycles, required 0", dones);
        end
        check_op("div50_5", OP_DIV, 32'd50, 32'd5, 32'd10, 1'b0, 33, 32);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b, res, expRes;
        logic [4:0] op;
        logic dz, after;
        int lat, bc, nbad;
        nbad = 0;
        for (int n = 0; n < 1000; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(1, 15);
                1:       b = $urandom_range(1, 100000);
                2:       b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if (b == '0) b = 32'd1;
            op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_MOD;
            expRes = (op == OP_DIV) ? (a / b) : (a % b);
            run_op(op, a, b, res, dz, lat, bc, after);
            total++;
            if (res !== expRes || dz !== 1'b0 || lat !== 33 || bc !== 32 || after !== 1'b0) begin
                bad++;
                nbad++;
                if (nbad <= 10)
                    $display("FAIL random op=%b a=%h b=%h: got %h dz=%b lat=%0d, required %h dz=0 lat=33",
                             op, a, b, res, dz, lat, expRes);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_div_mod();
        test_extremes();
        test_div_by_zero();
        test_invalid_op();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
